// File: rtl/vx_ecc_scrubber_pkg.sv
// Shared types and helpers for the ECC scrubber.
// Hamming sizing, data-bit placement, saturating increment.
package VX_ecc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_CHECK,
    ST_WR_REQ
  } scrub_state_e;

  localparam int SAT_W = 32;

  function automatic int calculate_hamming_bits(
    input int data_bits
  );
    int p;
    p = 0;
    while ((1 << p) < data_bits + p + 1) p++;
    return p;
  endfunction

  // Codeword position (1-based) of data bit idx;
  // powers of two are reserved for parity.
  function automatic int data_pos(input int idx);
    int pos;
    int seen;
    pos  = 0;
    seen = -1;
    while (seen < idx) begin
      pos++;
      if ((pos & (pos - 1)) != 0) seen++;
    end
    return pos;
  endfunction

  function automatic logic [SAT_W-1:0] sat_inc(
    input logic [SAT_W-1:0] v,
    input int               w
  );
    logic [SAT_W-1:0] top;
    top = (w >= SAT_W) ? '1
        : ((SAT_W'(1) << w) - SAT_W'(1));
    return (v == top) ? v : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/vx_ecc_scrubber_hamming.sv
// Combinational extended-Hamming SECDED encoder and decoder.
// Bit 0 holds overall parity; bits 1..N are classic positions.
module VX_hamming_enc
  import VX_ecc_pkg::*;
#(
  parameter int DATA_BITS = 128,
  localparam int PB = calculate_hamming_bits(DATA_BITS),
  localparam int N  = DATA_BITS + PB
) (
  input  logic [DATA_BITS-1:0] data_in,
  output logic [N:0]           data_out
);

  logic [N:1]    raw;
  logic [PB-1:0] acc;
  logic [N:0]    code;

  for (genvar j = 0; j < PB; j++) begin : g_par
    assign raw[1 << j] = 1'b0;
  end

  for (genvar i = 0; i < DATA_BITS; i++) begin : g_dat
    assign raw[data_pos(i)] = data_in[i];
  end

  always_comb begin
    acc = '0;
    for (int p = 1; p <= N; p++) begin
      if (raw[p]) acc = acc ^ PB'(p);
    end
    code      = {raw, 1'b0};
    for (int j = 0; j < PB; j++) begin
      code[1 << j] = acc[j];
    end
    code[0] = ^code[N:1];
  end

  assign data_out = code;

endmodule

module VX_hamming_dec
  import VX_ecc_pkg::*;
#(
  parameter int DATA_BITS = 128,
  localparam int PB = calculate_hamming_bits(DATA_BITS),
  localparam int N  = DATA_BITS + PB
) (
  input  logic [N:0]           data_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 corrected,
  output logic                 invalid
);

  logic [PB-1:0] syn;
  logic          par;

  always_comb begin
    syn = '0;
    for (int p = 1; p <= N; p++) begin
      if (data_in[p]) syn = syn ^ PB'(p);
    end
    par       = ^data_in;
    corrected = 1'b0;
    invalid   = 1'b0;
    // Odd parity: one flip at syn (0 = parity bit).
    // Even parity with nonzero syndrome: two flips.
    if (par) begin
      if (int'(syn) <= N) corrected = 1'b1;
      else                invalid   = 1'b1;
    end else if (syn != '0) begin
      invalid = 1'b1;
    end
  end

  for (genvar i = 0; i < DATA_BITS; i++) begin : g_out
    localparam int P = data_pos(i);
    assign data_out[i] = data_in[P]
                       ^ (corrected && syn == PB'(P));
  end

endmodule

// File: rtl/vx_ecc_scrubber.sv
// Background SECDED scrubber for a cache data array.
// Low-priority requester; yields to core writes via snooping.
module vx_ecc_scrubber
  import VX_ecc_pkg::*;
#(
  parameter int DATA_BITS     = 128,
  parameter int NUM_LINES     = 256,
  parameter int INTERVAL_BITS = 16,
  parameter int CNT_BITS      = 16,
  localparam int ENCODED_BITS =
    DATA_BITS + calculate_hamming_bits(DATA_BITS) + 1,
  localparam int AW = $clog2(NUM_LINES)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic [INTERVAL_BITS-1:0] interval,
  output logic                     rd_req_valid,
  input  logic                     rd_req_ready,
  output logic [AW-1:0]            rd_req_addr,
  input  logic                     rd_rsp_valid,
  input  logic [ENCODED_BITS-1:0]  rd_rsp_data,
  output logic                     wr_req_valid,
  input  logic                     wr_req_ready,
  output logic [AW-1:0]            wr_req_addr,
  output logic [ENCODED_BITS-1:0]  wr_req_data,
  input  logic                     core_wr_valid,
  input  logic [AW-1:0]            core_wr_addr,
  output logic [CNT_BITS-1:0]      corr_count,
  output logic [CNT_BITS-1:0]      uncorr_count,
  output logic [AW-1:0]            uncorr_addr,
  output logic                     uncorr_irq,
  output logic                     pass_done,
  input  logic                     clr_counts
);

  scrub_state_e state_q, state_d;

  logic [AW-1:0]            addr_q, addr_d;
  logic [INTERVAL_BITS-1:0] gap_q, gap_d;
  logic [ENCODED_BITS-1:0]  rdata_q, rdata_d;
  logic [ENCODED_BITS-1:0]  wdata_q, wdata_d;
  logic                     rd_v_q, rd_v_d;
  logic                     wr_v_q, wr_v_d;
  logic [CNT_BITS-1:0]      corr_q, corr_d;
  logic [CNT_BITS-1:0]      uncorr_q, uncorr_d;
  logic [AW-1:0]            uaddr_q, uaddr_d;
  logic                     irq_q, irq_d;
  logic                     pass_q, pass_d;
  logic                     stale_q, stale_d;

  logic [DATA_BITS-1:0]    dec_data;
  logic                    dec_corr;
  logic                    dec_inv;
  logic [ENCODED_BITS-1:0] enc_data;

  logic hit;
  logic do_next;
  logic corr_inc;
  logic uncorr_inc;

  VX_hamming_dec #(
    .DATA_BITS(DATA_BITS)
  ) u_dec (
    .data_in  (rdata_q),
    .data_out (dec_data),
    .corrected(dec_corr),
    .invalid  (dec_inv)
  );

  VX_hamming_enc #(
    .DATA_BITS(DATA_BITS)
  ) u_enc (
    .data_in (dec_data),
    .data_out(enc_data)
  );

  assign hit = core_wr_valid
            && core_wr_addr == addr_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    gap_d      = gap_q;
    rdata_d    = rdata_q;
    wdata_d    = wdata_q;
    rd_v_d     = rd_v_q;
    wr_v_d     = wr_v_q;
    corr_d     = corr_q;
    uncorr_d   = uncorr_q;
    uaddr_d    = uaddr_q;
    irq_d      = 1'b0;
    pass_d     = 1'b0;
    stale_d    = stale_q;
    do_next    = 1'b0;
    corr_inc   = 1'b0;
    uncorr_inc = 1'b0;

    if (hit && (state_q == ST_RD_WAIT
             || state_q == ST_CHECK
             || state_q == ST_WR_REQ)) begin
      stale_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_WAIT;
          gap_d   = interval;
        end
      end
      ST_WAIT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (gap_q == '0) begin
          state_d = ST_RD_REQ;
          rd_v_d  = 1'b1;
        end else begin
          gap_d = gap_q - INTERVAL_BITS'(1);
        end
      end
      ST_RD_REQ: begin
        if (rd_req_ready) begin
          state_d = ST_RD_WAIT;
          rd_v_d  = 1'b0;
        end
      end
      ST_RD_WAIT: begin
        if (rd_rsp_valid) begin
          state_d = ST_CHECK;
          rdata_d = rd_rsp_data;
        end
      end
      ST_CHECK: begin
        unique case (1'b1)
          dec_inv: begin
            uncorr_inc = 1'b1;
            uaddr_d    = addr_q;
            irq_d      = 1'b1;
            do_next    = 1'b1;
          end
          dec_corr: begin
            corr_inc = 1'b1;
            // A core write owns the line now; our copy is stale.
            if (stale_q || hit) begin
              do_next = 1'b1;
            end else begin
              wdata_d = enc_data;
              wr_v_d  = 1'b1;
              state_d = ST_WR_REQ;
            end
          end
          default: do_next = 1'b1;
        endcase
      end
      ST_WR_REQ: begin
        if (hit || wr_req_ready) begin
          wr_v_d  = 1'b0;
          do_next = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_next) begin
      addr_d  = addr_q + AW'(1);
      pass_d  = &addr_q;
      gap_d   = interval;
      stale_d = 1'b0;
      state_d = enable ? ST_WAIT : ST_IDLE;
    end

    if (clr_counts) begin
      corr_d   = '0;
      uncorr_d = '0;
    end else begin
      if (corr_inc) begin
        corr_d = CNT_BITS'(
          sat_inc(SAT_W'(corr_q), CNT_BITS));
      end
      if (uncorr_inc) begin
        uncorr_d = CNT_BITS'(
          sat_inc(SAT_W'(uncorr_q), CNT_BITS));
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      gap_q    <= '0;
      rdata_q  <= '0;
      wdata_q  <= '0;
      rd_v_q   <= 1'b0;
      wr_v_q   <= 1'b0;
      corr_q   <= '0;
      uncorr_q <= '0;
      uaddr_q  <= '0;
      irq_q    <= 1'b0;
      pass_q   <= 1'b0;
      stale_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      gap_q    <= gap_d;
      rdata_q  <= rdata_d;
      wdata_q  <= wdata_d;
      rd_v_q   <= rd_v_d;
      wr_v_q   <= wr_v_d;
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
      uaddr_q  <= uaddr_d;
      irq_q    <= irq_d;
      pass_q   <= pass_d;
      stale_q  <= stale_d;
    end
  end

  assign rd_req_valid = rd_v_q;
  assign rd_req_addr  = addr_q;
  assign wr_req_valid = wr_v_q;
  assign wr_req_addr  = addr_q;
  assign wr_req_data  = wdata_q;
  assign corr_count   = corr_q;
  assign uncorr_count = uncorr_q;
  assign uncorr_addr  = uaddr_q;
  assign uncorr_irq   = irq_q;
  assign pass_done    = pass_q;

endmodule

// File: tb/tb_vx_ecc_scrubber.sv
// Directed bench for vx_ecc_scrubber on a 4-line array.
// Codewords below are hand-computed extended-Hamming words.
module tb_vx_ecc_scrubber;

  localparam int DB = 128;
  localparam int NL = 4;
  localparam int IB = 16;
  localparam int CB = 4;
  localparam int EB = 137;
  localparam int AW = 2;

  logic          clk;
  logic          resetn;
  logic          enable;
  logic [IB-1:0] interval;
  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [AW-1:0] rd_req_addr;
  logic          rd_rsp_valid;
  logic [EB-1:0] rd_rsp_data;
  logic          wr_req_valid;
  logic          wr_req_ready;
  logic [AW-1:0] wr_req_addr;
  logic [EB-1:0] wr_req_data;
  logic          core_wr_valid;
  logic [AW-1:0] core_wr_addr;
  logic [CB-1:0] corr_count;
  logic [CB-1:0] uncorr_count;
  logic [AW-1:0] uncorr_addr;
  logic          uncorr_irq;
  logic          pass_done;
  logic          clr_counts;

  logic          rsp_a_v, rsp_b_v;
  logic [EB-1:0] rsp_a_d, rsp_b_d;
  logic          snp_a_v, snp_b_v;
  logic [AW-1:0] snp_a_addr, snp_b_addr;

  assign rd_rsp_valid  = rsp_a_v | rsp_b_v;
  assign rd_rsp_data   = rsp_b_v ? rsp_b_d : rsp_a_d;
  assign core_wr_valid = snp_a_v | snp_b_v;
  assign core_wr_addr  = snp_b_v ? snp_b_addr
                                 : snp_a_addr;

  vx_ecc_scrubber #(
    .DATA_BITS    (DB),
    .NUM_LINES    (NL),
    .INTERVAL_BITS(IB),
    .CNT_BITS     (CB)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .enable       (enable),
    .interval     (interval),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_data  (rd_rsp_data),
    .wr_req_valid (wr_req_valid),
    .wr_req_ready (wr_req_ready),
    .wr_req_addr  (wr_req_addr),
    .wr_req_data  (wr_req_data),
    .core_wr_valid(core_wr_valid),
    .core_wr_addr (core_wr_addr),
    .corr_count   (corr_count),
    .uncorr_count (uncorr_count),
    .uncorr_addr  (uncorr_addr),
    .uncorr_irq   (uncorr_irq),
    .pass_done    (pass_done),
    .clr_counts   (clr_counts)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [EB-1:0] got,
                     input logic [EB-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // data 0 -> 0; data 1 -> pos 1,2,3 + parity;
  // data 2 -> pos 1,4,5 + parity; data bit127 -> pos 8,128,136.
  function automatic logic [EB-1:0] gold_word(input int i);
    case (i)
      0:       return '0;
      1:       return EB'(137'h0f);
      2:       return EB'(137'h33);
      default: return (EB'(1) << 136) | (EB'(1) << 128)
                    | EB'(137'h101);
    endcase
  endfunction

  logic [EB-1:0] mem [NL];
  logic [EB-1:0] err [NL];
  logic          hold_rsp;
  int            snoop_addr;

  logic [AW-1:0] rd_log [$];
  int            rd_cyc [$];
  logic [AW-1:0] wa_log [$];
  logic [EB-1:0] wd_log [$];
  int            n_pass;
  int            n_irq;
  int            cyc;

  // Array model: 1-cycle read latency, write-back capture.
  initial begin
    logic          pend;
    logic [AW-1:0] paddr;
    for (int i = 0; i < NL; i++) mem[i] = gold_word(i);
    pend = 1'b0; paddr = '0;
    rsp_a_v = 1'b0; rsp_a_d = '0;
    snp_a_v = 1'b0; snp_a_addr = '0;
    n_pass = 0; n_irq = 0; cyc = 0;
    forever begin
      @(negedge clk); #1;
      cyc++;
      rsp_a_v = 1'b0;
      snp_a_v = 1'b0;
      if (pend && !hold_rsp) begin
        rsp_a_v = 1'b1;
        rsp_a_d = mem[paddr] ^ err[paddr];
        if (snoop_addr == int'(paddr)) begin
          snp_a_v    = 1'b1;
          snp_a_addr = paddr;
        end
      end
      pend = 1'b0;
      if (rd_req_valid && rd_req_ready) begin
        pend  = 1'b1;
        paddr = rd_req_addr;
        rd_log.push_back(rd_req_addr);
        rd_cyc.push_back(cyc);
      end
      if (wr_req_valid && wr_req_ready) begin
        wa_log.push_back(wr_req_addr);
        wd_log.push_back(wr_req_data);
        mem[wr_req_addr] = wr_req_data;
      end
      if (pass_done)  n_pass++;
      if (uncorr_irq) n_irq++;
    end
  end

  task automatic wait_pass();
    int n;
    n = 0;
    while (!pass_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("pass_done_seen", EB'(pass_done), 1);
  endtask

  task automatic run_pass();
    enable = 1'b1;
    wait_pass();
    enable = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic clear_counts();
    clr_counts = 1'b1;
    @(negedge clk);
    clr_counts = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rb, wb, pb, ib, n;
    resetn = 1'b0; enable = 1'b0; interval = 16'd2;
    rd_req_ready = 1'b1; wr_req_ready = 1'b1;
    clr_counts = 1'b0; hold_rsp = 1'b0;
    snoop_addr = -1;
    rsp_b_v = 1'b0; rsp_b_d = '0;
    snp_b_v = 1'b0; snp_b_addr = '0;
    for (int i = 0; i < NL; i++) err[i] = '0;

    repeat (3) @(negedge clk);
    chk("rst_rd_valid", EB'(rd_req_valid), 0);
    chk("rst_wr_valid", EB'(wr_req_valid), 0);
    chk("rst_corr", EB'(corr_count), 0);
    chk("rst_uncorr", EB'(uncorr_count), 0);
    chk("rst_irq", EB'(uncorr_irq), 0);
    chk("rst_pass", EB'(pass_done), 0);
    chk("rst_wdata", wr_req_data, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Clean sweep, interval 2: 6 cycles per line.
    rb = rd_log.size(); wb = wa_log.size(); pb = n_pass;
    run_pass();
    chk("sweep_reads", EB'(rd_log.size() - rb), 4);
    for (int i = 0; i < 4; i++)
      chk("sweep_addr", EB'(rd_log[rb + i]), EB'(i));
    chk("sweep_gap6", EB'(rd_cyc[rb+1] - rd_cyc[rb]), 6);
    chk("sweep_writes", EB'(wa_log.size() - wb), 0);
    chk("sweep_pass", EB'(n_pass - pb), 1);
    chk("sweep_corr", EB'(corr_count), 0);
    chk("sweep_uncorr", EB'(uncorr_count), 0);

    // Back-to-back: 4 cycles per line.
    interval = 16'd0;
    rb = rd_log.size();
    run_pass();
    chk("b2b_gap4", EB'(rd_cyc[rb+2] - rd_cyc[rb+1]), 4);

    // Single-bit error on line 2.
    clear_counts();
    wb = wa_log.size();
    err[2] = EB'(1) << 5;
    run_pass();
    err[2] = '0;
    chk("sbe_writes", EB'(wa_log.size() - wb), 1);
    chk("sbe_waddr", EB'(wa_log[wb]), 2);
    chk("sbe_wdata", wd_log[wb], gold_word(2));
    chk("sbe_corr", EB'(corr_count), 1);
    chk("sbe_uncorr", EB'(uncorr_count), 0);

    // Double-bit error on line 1.
    clear_counts();
    chk("clr_corr", EB'(corr_count), 0);
    wb = wa_log.size(); ib = n_irq;
    err[1] = (EB'(1) << 5) | (EB'(1) << 9);
    run_pass();
    err[1] = '0;
    chk("dbe_writes", EB'(wa_log.size() - wb), 0);
    chk("dbe_uncorr", EB'(uncorr_count), 1);
    chk("dbe_uaddr", EB'(uncorr_addr), 1);
    chk("dbe_irq_cycles", EB'(n_irq - ib), 1);
    chk("dbe_corr", EB'(corr_count), 0);

    // Snoop hit during RD_WAIT on a corrupted line 3.
    clear_counts();
    wb = wa_log.size();
    err[3] = EB'(1) << 136;
    snoop_addr = 3;
    run_pass();
    snoop_addr = -1;
    err[3] = '0;
    chk("snp_writes", EB'(wa_log.size() - wb), 0);
    chk("snp_corr", EB'(corr_count), 1);

    // Stalled write-back abandoned by a snoop hit.
    clear_counts();
    wb = wa_log.size();
    wr_req_ready = 1'b0;
    err[2] = EB'(1);
    enable = 1'b1;
    n = 0;
    while (!wr_req_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    err[2] = '0;
    chk("stall_wr_up", EB'(wr_req_valid), 1);
    repeat (10) @(negedge clk);
    chk("stall_wr_held", EB'(wr_req_valid), 1);
    chk("stall_waddr", EB'(wr_req_addr), 2);
    chk("stall_wdata", wr_req_data, gold_word(2));
    snp_b_addr = 2'd2;
    snp_b_v    = 1'b1;
    @(negedge clk);
    snp_b_v    = 1'b0;
    chk("stall_wr_drop", EB'(wr_req_valid), 0);
    wr_req_ready = 1'b1;
    wait_pass();
    enable = 1'b0;
    repeat (8) @(negedge clk);
    chk("stall_writes", EB'(wa_log.size() - wb), 0);
    chk("stall_corr", EB'(corr_count), 1);

    // Counter saturation at 4 bits: 16 corrections.
    clear_counts();
    wb = wa_log.size();
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < NL; i++)
        err[i] = EB'(1) << (i * 7 + 1);
      run_pass();
      for (int i = 0; i < NL; i++) err[i] = '0;
      if (p == 2) chk("sat_corr12", EB'(corr_count), 12);
    end
    chk("sat_corr15", EB'(corr_count), 15);
    chk("sat_writes", EB'(wa_log.size() - wb), 16);
    chk("sat_mem3", mem[3], gold_word(3));

    // Reset in RD_WAIT; late response must be ignored.
    hold_rsp = 1'b1;
    enable   = 1'b1;
    n = 0;
    while (!rd_req_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("rr_rd_up", EB'(rd_req_valid), 1);
    @(negedge clk);
    resetn = 1'b0;
    enable = 1'b0;
    #1;
    chk("rr_rd_valid", EB'(rd_req_valid), 0);
    chk("rr_wr_valid", EB'(wr_req_valid), 0);
    chk("rr_corr", EB'(corr_count), 0);
    chk("rr_uaddr", EB'(uncorr_addr), 0);
    chk("rr_wdata", wr_req_data, 0);
    chk("rr_rdaddr", EB'(rd_req_addr), 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    rsp_b_d = gold_word(1) ^ (EB'(1) << 5);
    rsp_b_v = 1'b1;
    @(negedge clk);
    rsp_b_v = 1'b0;
    repeat (6) @(negedge clk);
    chk("late_rd_valid", EB'(rd_req_valid), 0);
    chk("late_wr_valid", EB'(wr_req_valid), 0);
    chk("late_corr", EB'(corr_count), 0);
    chk("late_uncorr", EB'(uncorr_count), 0);
    hold_rsp = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
